// File: rtl/gray_seq_ctrl.sv
// Sweeps a binary range and emits binary/Gray pairs on a val/rdy stream.
// Define GRAY_SEQ_CTRL_REPEAT_EN to add the repeat_ input (wrap back to first).
module gray_seq_ctrl #(
    parameter int nbits = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [nbits-1:0] cfg_first,
    input  logic [nbits-1:0] cfg_last,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_bin,
    output logic [nbits-1:0] out_gray,
    output logic             busy,
`ifdef GRAY_SEQ_CTRL_REPEAT_EN
    input  logic             repeat_,
`endif
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [nbits-1:0] ONE = {{(nbits-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [nbits-1:0] first_q, first_d;
    logic [nbits-1:0] last_q, last_d;
    logic [nbits-1:0] bin_q, bin_d;
    logic             val_q, val_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             rep_w;

`ifdef GRAY_SEQ_CTRL_REPEAT_EN
    assign rep_w = repeat_;
`else
    assign rep_w = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        bin_d   = bin_q;
        val_d   = val_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    first_d = cfg_first;
                    last_d  = cfg_last;
                    bin_d   = cfg_first;
                    state_d = S_RUN;
                    val_d   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                // abort beats a coincident final transfer; bin holds
                if (abort) begin
                    state_d = S_IDLE;
                    val_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (out_rdy) begin
                    if (bin_q == last_q) begin
                        if (rep_w) begin
                            bin_d = first_q;
                        end else begin
                            state_d = S_DONE;
                            val_d   = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        bin_d = bin_q + ONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                val_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            first_q <= '0;
            last_q  <= '0;
            bin_q   <= '0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            bin_q   <= bin_d;
            val_q   <= val_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_val  = val_q;
    assign out_bin  = bin_q;
    assign out_gray = bin_q ^ (bin_q >> 1);
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Scoreboard bench for gray_seq_ctrl: random sweeps against a range/Gray-table model.
// Repeat scenarios are exercised when GRAY_SEQ_CTRL_REPEAT_EN is defined.
module tb_gray_seq_ctrl;

    localparam int NB = 4;
    localparam int N  = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NB-1:0] cfg_first = '0;
    logic [NB-1:0] cfg_last = '0;
    logic          out_val;
    logic          out_rdy = 1'b0;
    logic [NB-1:0] out_bin;
    logic [NB-1:0] out_gray;
    logic          busy;
    logic          done;
    logic          repeat_ = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];
    int done_tok = 0;
    int gtab[N];

    gray_seq_ctrl #(.nbits(NB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .abort(abort),
        .cfg_first(cfg_first),
        .cfg_last(cfg_last),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .out_bin(out_bin),
        .out_gray(out_gray),
        .busy(busy),
`ifdef GRAY_SEQ_CTRL_REPEAT_EN
        .repeat_(repeat_),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // monitor: pops the scoreboard on every accepted pair
    bit stalled = 0;
    int stall_bin = 0;
    bit have_prev = 0;
    int prev_bin = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            stalled   = 0;
            have_prev = 0;
        end else begin
            chk("gray_of_bin", out_gray, gtab[out_bin]);
            if (stalled && out_val)
                chk("stall_hold", out_bin, stall_bin);
            if (out_val && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    chk("xfer_bin", out_bin, e);
                    chk("xfer_gray", out_gray, gtab[e]);
                    if (have_prev && e == (prev_bin + 1) % N)
                        chk("gray_one_bit", $countones(gtab[e] ^ gtab[prev_bin]), 1);
                    prev_bin  = e;
                    have_prev = 1;
                end
            end
            if (done) begin
                chk("done_expected", done_tok > 0, 1);
                chk("done_no_val", out_val, 0);
                if (done_tok > 0) done_tok--;
                have_prev = 0;
            end
            stalled   = out_val && !out_rdy;
            stall_bin = out_bin;
        end
    end

    task automatic sweep(input int first, input int last, input int pct,
                         input int abort_at, input int reps, input bit mid_start);
        int len;
        int idx;
        int cyc;
        bit r;
        bit ab;
        bit fin;
        len = ((last - first) % N + N) % N + 1;
        @(posedge clk); #1;
        start     = 1'b1;
        abort     = 1'($urandom % 2);
        cfg_first = NB'(first);
        cfg_last  = NB'(last);
        out_rdy   = 1'($urandom % 2);
        repeat_   = 1'b0;
        @(posedge clk); #1;
        start     = 1'b0;
        cfg_first = NB'($urandom);
        cfg_last  = NB'($urandom);
        chk("busy_run", busy, 1);
        chk("val_first", out_val, 1);
        idx = 0;
        fin = 0;
        cyc = 0;
        ab  = 0;
        while (!fin) begin
            r         = ($urandom % 100) < pct;
            ab        = (idx == abort_at) && (reps == 0);
            out_rdy   = r;
            abort     = ab;
            start     = mid_start ? 1'($urandom % 2) : 1'b0;
            cfg_first = NB'($urandom);
            cfg_last  = NB'($urandom);
            repeat_   = 1'b0;
            if (r) begin
                exp_q.push_back((first + idx) % N);
                if (idx == len - 1 && !ab) begin
                    if (reps > 0) repeat_ = 1'b1;
                    else done_tok++;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (ab) begin
                fin = 1;
            end else if (r) begin
                if (idx == len - 1) begin
                    if (reps > 0) begin
                        reps--;
                        idx = 0;
                    end else begin
                        fin = 1;
                    end
                end else begin
                    idx++;
                end
            end
            if (cyc > 2000) begin
                chk("sweep_timeout", cyc, 0);
                fin = 1;
            end
        end
        start   = 1'($urandom % 2);
        abort   = 1'($urandom % 2);
        out_rdy = 1'($urandom % 2);
        repeat_ = 1'b0;
        if (ab) begin
            chk("abort_val", out_val, 0);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_hold", out_bin, (first + idx) % N);
            start = 1'b0;
        end else begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 1);
            chk("done_val", out_val, 0);
            @(posedge clk); #1;
            start = 1'b0;
            chk("idle_done", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_val", out_val, 0);
        end
        abort   = 1'b0;
        out_rdy = 1'b0;
    endtask

    initial begin
        gtab[0] = 0;
        gtab[1] = 1;
        for (int k = 1; k < NB; k++)
            for (int i = 0; i < (1 << k); i++)
                gtab[(1 << (k + 1)) - 1 - i] = gtab[i] | (1 << k);

        #2;
        chk("rst_val", out_val, 0);
        chk("rst_bin", out_bin, 0);
        chk("rst_gray", out_gray, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        sweep(0, 3, 100, -1, 0, 0);
        sweep(4, 6, 50, -1, 0, 0);
        sweep(14, 1, 100, -1, 0, 0);
        sweep(9, 9, 100, -1, 0, 0);
        sweep(5, 4, 100, -1, 0, 0);
        sweep(0, 7, 100, 2, 0, 1);
        sweep(0, 7, 100, 1, 0, 0);
        sweep(0, 7, 100, 7, 0, 0);
        sweep(3, 5, 60, 2, 0, 1);

        // asynchronous reset mid-sweep
        @(posedge clk); #1;
        start = 1'b1; cfg_first = 4'd0; cfg_last = 4'd7;
        @(posedge clk); #1;
        start = 1'b0; out_rdy = 1'b1;
        exp_q.push_back(0);
        @(posedge clk); #1;
        exp_q.push_back(1);
        @(posedge clk); #1;
        out_rdy = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_val", out_val, 0);
        chk("mrst_bin", out_bin, 0);
        chk("mrst_gray", out_gray, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        chk("mrst_idle", out_val, 0);
        sweep(0, 7, 100, -1, 0, 0);

`ifdef GRAY_SEQ_CTRL_REPEAT_EN
        sweep(2, 3, 100, -1, 3, 0);
        sweep(2, 3, 70, -1, 2, 1);
`endif

        for (int s = 0; s < 40; s++) begin
            int reps;
            reps = 0;
`ifdef GRAY_SEQ_CTRL_REPEAT_EN
            reps = $urandom % 3;
`endif
            sweep($urandom % N, $urandom % N, 30 + $urandom % 71,
                  ($urandom % 3 == 0) ? int'($urandom % N) : -1,
                  reps, 1'($urandom % 2));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_tokens_left", done_tok, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
